// File: rtl/maj_fold_ctrl_if.sv
// Handshake bundle between a vector producer/result consumer and maj_fold_ctrl.
interface maj_fold_ctrl_if #(
    parameter int unsigned N     = 51,
    parameter int unsigned CHUNK = 8
);
    localparam int unsigned NCH   = (N + CHUNK - 1) / CHUNK;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned CHK_W = $clog2(NCH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_x;
    logic             early_en;
    logic             out_valid;
    logic             out_ready;
    logic             out_y;
    logic [CNT_W-1:0] out_cnt;
    logic [CHK_W-1:0] out_chunks;

    // Producer/consumer side: offers vectors, accepts results.
    modport master (
        output in_valid, in_x, early_en, out_ready,
        input  in_ready, out_valid, out_y, out_cnt, out_chunks
    );

    // Controller side.
    modport slave (
        input  in_valid, in_x, early_en, out_ready,
        output in_ready, out_valid, out_y, out_cnt, out_chunks
    );
endinterface

// File: rtl/maj_fold_ctrl.sv
// Time-multiplexed N-input majority: folds the vector CHUNK bits per clock
// into a running popcount, optionally stopping once the outcome is decided.
module maj_fold_ctrl #(
    parameter int unsigned N     = 51,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    maj_fold_ctrl_if.slave   bus
);
    localparam int unsigned NCH    = (N + CHUNK - 1) / CHUNK;
    localparam int unsigned THRESH = (N + 1) / 2;
    localparam int unsigned XW     = NCH * CHUNK;
    localparam int unsigned CNT_W  = $clog2(N + 1);
    localparam int unsigned CHK_W  = $clog2(NCH + 1);
    localparam int unsigned PC_W   = $clog2(CHUNK + 1);
    localparam int unsigned OFS_W  = $clog2(XW + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Registered state and datapath
    logic [1:0]       state_q,      state_d;
    logic [XW-1:0]    x_q,          x_d;
    logic             early_q,      early_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CHK_W-1:0] idx_q,        idx_d;
    logic             in_ready_q,   in_ready_d;
    logic             out_valid_q,  out_valid_d;
    logic             out_y_q,      out_y_d;
    logic [CNT_W-1:0] out_cnt_q,    out_cnt_d;
    logic [CHK_W-1:0] out_chunks_q, out_chunks_d;

    // Per-cycle fold values
    logic [CHUNK-1:0] chunk_c;
    logic [PC_W-1:0]  pc_c;
    logic [CNT_W-1:0] cnt_sum_c;
    logic [CHK_W-1:0] idx_nx_c;
    logic [OFS_W-1:0] ofs_nx_c;
    logic [CNT_W-1:0] rem_nx_c;
    logic             hit_hi_c;
    logic             hit_lo_c;
    logic             last_c;
    logic             decide_c;

    // Count of set bits in one chunk.
    function automatic logic [PC_W-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // Fold datapath: current chunk, updated count, remaining real bits, decision.
    always_comb begin
        chunk_c   = CHUNK'(x_q >> (OFS_W'(idx_q) * OFS_W'(CHUNK)));
        pc_c      = popcnt(chunk_c);
        cnt_sum_c = cnt_q + CNT_W'(pc_c);
        idx_nx_c  = idx_q + CHK_W'(1);
        ofs_nx_c  = OFS_W'(idx_nx_c) * OFS_W'(CHUNK);
        rem_nx_c  = (ofs_nx_c >= OFS_W'(N)) ? '0 : CNT_W'(OFS_W'(N) - ofs_nx_c);
        hit_hi_c  = (cnt_sum_c >= CNT_W'(THRESH));
        hit_lo_c  = ((SUM_W'(cnt_sum_c) + SUM_W'(rem_nx_c)) < SUM_W'(THRESH));
        last_c    = (idx_nx_c == CHK_W'(NCH));
        decide_c  = last_c || (early_q && (hit_hi_c || hit_lo_c));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        early_d      = early_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        out_cnt_d    = out_cnt_q;
        out_chunks_d = out_chunks_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d     = XW'(bus.in_x);
                    early_d = bus.early_en;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                cnt_d = cnt_sum_c;
                idx_d = idx_nx_c;
                if (decide_c) begin
                    // hit_hi alone gives the answer: when any rule fires it agrees with it.
                    out_valid_d  = 1'b1;
                    out_y_d      = hit_hi_c;
                    out_cnt_d    = cnt_sum_c;
                    out_chunks_d = idx_nx_c;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            early_q      <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_y_q      <= 1'b0;
            out_cnt_q    <= '0;
            out_chunks_q <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            early_q      <= early_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            out_cnt_q    <= out_cnt_d;
            out_chunks_q <= out_chunks_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_cnt    = out_cnt_q;
    assign bus.out_chunks = out_chunks_q;

endmodule

// File: tb/tb_maj_fold_ctrl.sv
// Directed bench for maj_fold_ctrl (N=51, CHUNK=8, threshold 26).
module tb_maj_fold_ctrl;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    maj_fold_ctrl_if #(.N(51), .CHUNK(8)) bus ();

    maj_fold_ctrl #(.N(51), .CHUNK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one vector and wait for out_valid; lat = edges from accept to out_valid.
    task automatic send_vec(input logic [50:0] x, input logic e, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int n = 0; n < 20 && !bus.in_ready; n++) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.early_en = e;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Complete the output handshake.
    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        tests_run++;
        if (bus.out_y !== 1'b0) begin tests_failed++; $display("FAIL reset_out_y got %b want 0", bus.out_y); end
        tests_run++;
        if (bus.out_cnt !== 6'd0) begin tests_failed++; $display("FAIL reset_out_cnt got %0d want 0", bus.out_cnt); end
        tests_run++;
        if (bus.out_chunks !== 3'd0) begin tests_failed++; $display("FAIL reset_out_chunks got %0d want 0", bus.out_chunks); end
    endtask

    task automatic test_all_ones();
        int lat; bit ok;
        send_vec({51{1'b1}}, 1'b1, lat, ok);
        tests_run++;
        if (!ok || lat != 4) begin tests_failed++; $display("FAIL ones_latency got %0d (ok=%b) want 4", lat, ok); end
        tests_run++;
        if (bus.out_y !== 1'b1) begin tests_failed++; $display("FAIL ones_y got %b want 1", bus.out_y); end
        tests_run++;
        if (bus.out_cnt !== 6'd32) begin tests_failed++; $display("FAIL ones_cnt got %0d want 32", bus.out_cnt); end
        tests_run++;
        if (bus.out_chunks !== 3'd4) begin tests_failed++; $display("FAIL ones_chunks got %0d want 4", bus.out_chunks); end
        consume();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL ones_drop_valid got %b want 0", bus.out_valid); end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL ones_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_all_zeros();
        int lat; bit ok;
        send_vec(51'd0, 1'b1, lat, ok);
        tests_run++;
        if (!ok || lat != 4) begin tests_failed++; $display("FAIL zeros_latency got %0d (ok=%b) want 4", lat, ok); end
        tests_run++;
        if (bus.out_y !== 1'b0) begin tests_failed++; $display("FAIL zeros_y got %b want 0", bus.out_y); end
        tests_run++;
        if (bus.out_cnt !== 6'd0) begin tests_failed++; $display("FAIL zeros_cnt got %0d want 0", bus.out_cnt); end
        tests_run++;
        if (bus.out_chunks !== 3'd4) begin tests_failed++; $display("FAIL zeros_chunks got %0d want 4", bus.out_chunks); end
        consume();
    endtask

    task automatic test_exact_thresh();
        int lat; bit ok;
        logic [50:0] x;
        x = 51'((64'd1 << 26) - 64'd1);
        send_vec(x, 1'b0, lat, ok);
        tests_run++;
        if (!ok || lat != 7) begin tests_failed++; $display("FAIL thr_full_latency got %0d (ok=%b) want 7", lat, ok); end
        tests_run++;
        if (bus.out_y !== 1'b1 || bus.out_cnt !== 6'd26 || bus.out_chunks !== 3'd7) begin
            tests_failed++;
            $display("FAIL thr_full_result got y=%b cnt=%0d ch=%0d want y=1 cnt=26 ch=7", bus.out_y, bus.out_cnt, bus.out_chunks);
        end
        consume();
        send_vec(x, 1'b1, lat, ok);
        tests_run++;
        if (!ok || lat != 4) begin tests_failed++; $display("FAIL thr_early_latency got %0d (ok=%b) want 4", lat, ok); end
        tests_run++;
        if (bus.out_y !== 1'b1 || bus.out_cnt !== 6'd26 || bus.out_chunks !== 3'd4) begin
            tests_failed++;
            $display("FAIL thr_early_result got y=%b cnt=%0d ch=%0d want y=1 cnt=26 ch=4", bus.out_y, bus.out_cnt, bus.out_chunks);
        end
        consume();
    endtask

    task automatic test_below_thresh();
        int lat; bit ok;
        logic [50:0] x;
        x = 51'((64'd1 << 51) - (64'd1 << 26));
        send_vec(x, 1'b1, lat, ok);
        tests_run++;
        if (!ok || lat != 4) begin tests_failed++; $display("FAIL below_early_latency got %0d (ok=%b) want 4", lat, ok); end
        tests_run++;
        if (bus.out_y !== 1'b0 || bus.out_cnt !== 6'd6 || bus.out_chunks !== 3'd4) begin
            tests_failed++;
            $display("FAIL below_early_result got y=%b cnt=%0d ch=%0d want y=0 cnt=6 ch=4", bus.out_y, bus.out_cnt, bus.out_chunks);
        end
        consume();
        send_vec(x, 1'b0, lat, ok);
        tests_run++;
        if (!ok || lat != 7) begin tests_failed++; $display("FAIL below_full_latency got %0d (ok=%b) want 7", lat, ok); end
        tests_run++;
        if (bus.out_y !== 1'b0 || bus.out_cnt !== 6'd25 || bus.out_chunks !== 3'd7) begin
            tests_failed++;
            $display("FAIL below_full_result got y=%b cnt=%0d ch=%0d want y=0 cnt=25 ch=7", bus.out_y, bus.out_cnt, bus.out_chunks);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat; bit ok;
        send_vec({51{1'b1}}, 1'b1, lat, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL bp_timeout got no out_valid want out_valid"); end
        bus.in_valid = 1'b1;
        bus.in_x     = 51'd0;
        bus.early_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_y !== 1'b1 || bus.out_cnt !== 6'd32 ||
                bus.out_chunks !== 3'd4 || bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d got v=%b y=%b cnt=%0d ch=%0d rdy=%b want v=1 y=1 cnt=32 ch=4 rdy=0",
                         c, bus.out_valid, bus.out_y, bus.out_cnt, bus.out_chunks, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        repeat (9) @(posedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_no_second_capture got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_accum();
        int lat; bit ok; bit seen;
        logic [63:0] r;
        logic [50:0] x;
        int pc;
        // Accept edge E, then raise rst across edge E+3 (third accumulate cycle).
        bus.in_valid = 1'b1;
        bus.in_x     = {51{1'b1}};
        bus.early_en = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_cnt !== 6'd0 || bus.out_chunks !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_state got v=%b rdy=%b cnt=%0d ch=%0d want v=0 rdy=1 cnt=0 ch=0",
                     bus.out_valid, bus.in_ready, bus.out_cnt, bus.out_chunks);
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin tests_failed++; $display("FAIL rst_mid_discard got out_valid=1 want 0"); end

        for (int t = 0; t < 6; t++) begin
            r  = {$urandom(), $urandom()};
            x  = r[50:0];
            pc = 0;
            for (int b = 0; b < 51; b++) pc += int'(x[b]);
            send_vec(x, 1'(t & 1), lat, ok);
            tests_run++;
            if (!ok || bus.out_y !== 1'(pc >= 26)) begin
                tests_failed++;
                $display("FAIL rand_y[%0d] got y=%b (ok=%b) want %b pc=%0d", t, bus.out_y, ok, (pc >= 26), pc);
            end
            if ((t & 1) == 0) begin
                tests_run++;
                if (bus.out_cnt !== 6'(pc) || bus.out_chunks !== 3'd7 || lat != 7) begin
                    tests_failed++;
                    $display("FAIL rand_full[%0d] got cnt=%0d ch=%0d lat=%0d want cnt=%0d ch=7 lat=7",
                             t, bus.out_cnt, bus.out_chunks, lat, pc);
                end
            end
            consume();
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.early_en  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_exact_thresh();
        test_below_thresh();
        test_backpressure();
        test_reset_mid_accum();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
